// File: rtl/cpu_state_dump.sv
// cpu_state_dump: hardware readout of the CPU run state.
// On start it captures the run counters and the PC, then streams the counters,
// the 32 architectural registers and the low data-memory words as 32-bit words
// over a valid/ready interface. It also owns the cycle/stall/flush counters.
module cpu_state_dump #(
  parameter int MEM_WORDS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [4:0]  reg_addr_o,
  input  logic [31:0] reg_data_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_data_i,
  output logic        dump_valid_o,
  input  logic        dump_ready_i,
  output logic [31:0] dump_data_o,
  output logic        dump_last_o,
  output logic        busy_o,
  output logic        done_o
);

  // Word layout: 4 header words, 32 registers, then MEM_WORDS memory words.
  localparam int NWORDS = 36 + MEM_WORDS;
  localparam int IDX_W  = $clog2(NWORDS + 1);
  localparam logic [IDX_W-1:0] IDX_REG0 = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_MEM0 = IDX_W'(36);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;

  logic [31:0]       cycle_r;
  logic [31:0]       stall_r;
  logic [31:0]       flush_r;
  logic [31:0]       snap_pc_r;
  logic [31:0]       snap_stall_r;
  logic [31:0]       snap_flush_r;

  // Index of the word currently held in the output register.
  logic [IDX_W-1:0]  widx_r;
  logic [31:0]       data_r;
  logic              valid_r;
  logic              last_r;
  logic              busy_r;
  logic              done_r;

  logic              accept_s;
  logic [IDX_W-1:0]  nidx_s;
  logic [31:0]       word_s;
  logic [4:0]        reg_addr_s;
  logic [31:0]       mem_addr_s;
  logic [IDX_W-1:0]  widx_nxt_s;
  logic [31:0]       data_nxt_s;
  logic              valid_nxt_s;
  logic              last_nxt_s;
  logic              done_nxt_s;
  logic              snap_en_s;

  assign accept_s = valid_r & dump_ready_i;

  // Index of the next word to load: word 0 from IDLE, otherwise the successor.
  always_comb begin
    nidx_s = '0;
    if (state_r == ST_IDLE) begin
      nidx_s = '0;
    end else begin
      nidx_s = widx_r + IDX_W'(1);
    end
  end

  // Register-file / memory read addresses for the next word; 0 when unused.
  always_comb begin
    reg_addr_s = 5'd0;
    mem_addr_s = 32'd0;
    if ((state_r == ST_SEND) && (nidx_s >= IDX_REG0) && (nidx_s < IDX_MEM0)) begin
      reg_addr_s = 5'(nidx_s - IDX_REG0);
    end else if ((state_r == ST_SEND) && (nidx_s >= IDX_MEM0) && (nidx_s <= IDX_LAST)) begin
      mem_addr_s = 32'(nidx_s - IDX_MEM0) << 2;
    end else begin
      reg_addr_s = 5'd0;
      mem_addr_s = 32'd0;
    end
  end

  // Select the value of the next word. Word 0 is taken straight from the live
  // counter on the start edge, so the output register itself is its snapshot.
  always_comb begin
    word_s = 32'd0;
    case (nidx_s)
      IDX_W'(0): word_s = cycle_r;
      IDX_W'(1): word_s = snap_pc_r;
      IDX_W'(2): word_s = snap_stall_r;
      IDX_W'(3): word_s = snap_flush_r;
      default: begin
        if (nidx_s < IDX_MEM0) begin
          word_s = reg_data_i;
        end else begin
          word_s = mem_data_i;
        end
      end
    endcase
  end

  // Next-state and output-register update logic.
  always_comb begin
    state_nxt_s = state_r;
    widx_nxt_s  = widx_r;
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    last_nxt_s  = last_r;
    done_nxt_s  = 1'b0;
    snap_en_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          state_nxt_s = ST_SEND;
          widx_nxt_s  = nidx_s;
          data_nxt_s  = word_s;
          valid_nxt_s = 1'b1;
          last_nxt_s  = (nidx_s == IDX_LAST);
          snap_en_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (accept_s && last_r) begin
          state_nxt_s = ST_DONE;
          valid_nxt_s = 1'b0;
          last_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
        end else if (accept_s) begin
          widx_nxt_s  = nidx_s;
          data_nxt_s  = word_s;
          last_nxt_s  = (nidx_s == IDX_LAST);
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
      end
    endcase
  end

  // State register and registered stream/status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      widx_r  <= '0;
      data_r  <= 32'd0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      widx_r  <= widx_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      last_r  <= last_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= done_nxt_s;
    end
  end

  // Free-running cycle counter plus saturating stall and flush counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_r <= 32'd0;
      stall_r <= 32'd0;
      flush_r <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
      if (stall_i && (stall_r != 32'hFFFF_FFFF)) begin
        stall_r <= stall_r + 32'd1;
      end
      if (flush_i && (flush_r != 32'hFFFF_FFFF)) begin
        flush_r <= flush_r + 32'd1;
      end
    end
  end

  // Header snapshot on the start edge; stall/flush of that edge are excluded.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_pc_r    <= 32'd0;
      snap_stall_r <= 32'd0;
      snap_flush_r <= 32'd0;
    end else if (snap_en_s) begin
      snap_pc_r    <= pc_i;
      snap_stall_r <= stall_r;
      snap_flush_r <= flush_r;
    end
  end

  assign reg_addr_o   = reg_addr_s;
  assign mem_addr_o   = mem_addr_s;
  assign dump_valid_o = valid_r;
  assign dump_data_o  = data_r;
  assign dump_last_o  = last_r;
  assign busy_o       = busy_r;
  assign done_o       = done_r;

endmodule

// File: doc/cpu_state_dump.md
# cpu_state_dump

Hardware state-readout engine for the pipelined RISC-V CPU. On a start pulse it snapshots the run counters and PC, then walks the register file and the low words of data memory. It streams every value out as 32-bit words over a valid/ready interface. It does the same job as the simulation bench's per-cycle register and memory print, but in hardware, so the dump is available on FPGA or to an external trace sink. It also owns the cycle, stall and flush counters.

## Interface
Parameters:
- MEM_WORDS, default 8: number of 32-bit data-memory words dumped, starting at byte address 0x00.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset; one clock, reset is synchronous and active-high.
- start_i  in  1  dump request; sampled only in IDLE.
- pc_i  in  32  current PC (PC.pc_o).
- stall_i  in  1  pipeline stall indication this cycle.
- flush_i  in  1  pipeline flush indication this cycle.
- reg_addr_o  out  5  register-file read address (combinational read).
- reg_data_i  in  32  register-file read data, same cycle.
- mem_addr_o  out  32  data-memory byte address, word aligned (combinational read).
- mem_data_i  in  32  little-endian word at mem_addr_o, same cycle.
- dump_valid_o  out  1  dump_data_o holds a word.
- dump_ready_i  in  1  sink accepts the word this cycle.
- dump_data_o  out  32  dump word.
- dump_last_o  out  1  current word is the final word of the dump.
- busy_o  out  1  a dump is in progress.
- done_o  out  1  one-cycle pulse after the last word is accepted.

## Operation
- The block keeps three counters, each 32 bits.
  - cycle: increments every cycle when not in reset; wraps at 2^32.
  - stall: increments when stall_i=1; saturates at 0xFFFFFFFF.
  - flush: increments when flush_i=1; saturates at 0xFFFFFFFF.
- States and transitions:
  - IDLE → SEND when start_i=1.
  - SEND → DONE when the word with dump_last_o=1 is accepted.
  - DONE → IDLE unconditionally after one cycle.
- Word order, 36+MEM_WORDS words in total, index w:
  - w=0: cycle.
  - w=1: PC.
  - w=2: stall.
  - w=3: flush.
  - w=4..35: x0..x31.
  - w=36..: data-memory word j at byte address 4*j, for j=0..MEM_WORDS-1.
- Snapshots and live reads:
  - At the accepting edge the block snapshots cycle, pc_i, stall and flush into holding registers. Words 0–3 come from these snapshots.
  - Register and memory words are read live, at the cycle they are loaded into the output register.
- Address outputs:
  - reg_addr_o = the register index of the next word to load, and 0 otherwise.
  - mem_addr_o = 4*j of the next word to load, and 0 otherwise.
- Output register:
  - A single-entry output register.
  - A word is transferred when dump_valid_o && dump_ready_i.
  - On transfer, the next word loads in the same edge, so a back-to-back stream is possible.
  - With dump_ready_i=0, dump_data_o and dump_last_o hold stable.
- start_i while busy (SEND or DONE) is ignored; it is not queued.
- Reset mid-dump aborts the dump: state goes to IDLE, the output is invalidated and all counters clear. No done_o pulse is issued.

## Timing
- Reset values: every output is 0, including reg_addr_o and mem_addr_o. The cycle, stall and flush counters are 0 and state is IDLE.
- Start latency: start_i=1 in IDLE at edge k gives, after edge k:
  - busy_o=1, dump_valid_o=1, dump_data_o = cycle value as sampled at edge k (pre-increment).
- Throughput: with dump_ready_i held at 1, one word per cycle. Word w is valid in cycle k+1+w.
- The last word carries dump_last_o=1. Its accepting edge clears dump_valid_o, sets done_o=1 for exactly one cycle and keeps busy_o=1 (DONE). The next edge returns busy_o to 0 (IDLE).
- Earliest new start: start_i is honoured at the edge after done_o falls, not in the done_o cycle.
- Counters never stall; they keep counting during a dump.
- stall_i and flush_i asserted on the snapshot edge are excluded from the snapshot and included in later dumps.
- Stall counter at 0xFFFFFFFF with stall_i=1 stays at 0xFFFFFFFF; the same rule applies to flush.

## Test plan
- Reset, then 10 idle cycles, pc_i=0x20, start_i at cycle 10 with ready=1:
  - words 0–3 = 10, 0x20, 0, 0;
  - 44 words in 44 consecutive cycles;
  - dump_last_o only on word 43;
  - done_o pulses once.
- Register file preloaded with x[i]=i*3 and memory word 0 = 5, others 0:
  - words 4..35 = 0,3,…,93;
  - word 36 = 5;
  - words 37..43 = 0;
  - reg_addr_o and mem_addr_o sequence correct.
- Random dump_ready_i (50%):
  - dump_data_o stable whenever valid && !ready;
  - no word lost or duplicated;
  - order identical to the ready=1 case.
- stall_i high for 7 cycles and flush_i high for 2 cycles before start, both also high on the start edge:
  - words 2–3 = 7 and 2;
  - a second dump reports at least 8 and 3.
- start_i pulsed mid-dump, and in the done_o cycle:
  - both ignored, exactly one dump emitted;
  - start one cycle after done_o begins a new dump.
- rst_i asserted at word 20:
  - next cycle dump_valid_o=0, busy_o=0, done_o never pulses;
  - a subsequent start gives word 0 = cycles elapsed since reset deassertion.
